// File: rtl/capture_wr.sv
// capture_wr: AXI4 write master packing a 64-bit pixel stream into 128-B aligned 16-beat INCR bursts.
// AWVALID rises one cycle after 16 words are buffered; S_READY falls only when an active frame's FIFO is full.

module capture_wr_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_push_vld,
  input  logic [W-1:0]               i_push_dat,
  input  logic                       i_pop_rdy,
  output logic [W-1:0]               o_head_dat,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full     = (r_cnt == (AW+1)'(DEPTH));
  assign o_count    = r_cnt;
  assign o_head_dat = r_mem[r_rp];
  assign w_push     = i_push_vld && !o_full;
  assign w_pop      = i_pop_rdy && (r_cnt != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp] <= i_push_dat;
  end
endmodule

module capture_wr #(
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 64,
  parameter int FIFO_DEPTH              = 32,
  parameter int BURSTS_PER_FRAME        = 2400
) (
  input  logic                                ACLK,
  input  logic                                ARESETN,
  input  logic                                M_AXI_AWREADY,
  output logic                                M_AXI_AWVALID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]       M_AXI_AWADDR,
  output logic [7:0]                          M_AXI_AWLEN,
  output logic [2:0]                          M_AXI_AWSIZE,
  output logic [1:0]                          M_AXI_AWBURST,
  output logic [3:0]                          M_AXI_AWCACHE,
  output logic [2:0]                          M_AXI_AWPROT,
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0]  M_AXI_AWID,
  input  logic                                M_AXI_WREADY,
  output logic                                M_AXI_WVALID,
  output logic [C_M_AXI_DATA_WIDTH-1:0]       M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]     M_AXI_WSTRB,
  output logic                                M_AXI_WLAST,
  input  logic                                M_AXI_BVALID,
  input  logic [1:0]                          M_AXI_BRESP,
  output logic                                M_AXI_BREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]       S_DATA,
  input  logic                                S_VALID,
  output logic                                S_READY,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]       CAPADDR,
  input  logic                                CAPON,
  output logic                                FRAME_DONE,
  output logic                                BRESP_ERR
);
  localparam int NB   = C_M_AXI_DATA_WIDTH / 8;
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW   = (BURSTS_PER_FRAME > 1) ? $clog2(BURSTS_PER_FRAME) : 1;
  localparam logic [CW-1:0] LAST_BURST = CW'(BURSTS_PER_FRAME - 1);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t                          r_state;
  logic                            r_active;
  logic                            r_awvalid;
  logic                            r_wvalid;
  logic                            r_wlast;
  logic                            r_bready;
  logic                            r_frame_done;
  logic                            r_bresp_err;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [CW-1:0]                   r_burst_cnt;
  logic [3:0]                      r_beat;

  logic                            w_start;
  logic                            w_push;
  logic                            w_pop;
  logic                            w_full;
  logic [CNTW-1:0]                 w_count;
  logic [C_M_AXI_DATA_WIDTH-1:0]   w_head;
  logic [C_M_AXI_DATA_WIDTH-1:0]   w_wdata;
  logic                            w_unused;

  assign w_start  = (r_state == S_IDLE) && !r_active && CAPON;
  assign w_push   = r_active && S_VALID && !w_full;
  assign w_pop    = r_wvalid && M_AXI_WREADY;
  assign w_unused = ^CAPADDR[6:0];

  capture_wr_fifo #(
    .W     (C_M_AXI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (ACLK),
    .i_rst_n    (ARESETN),
    .i_flush    (w_start),
    .i_push_vld (w_push),
    .i_push_dat (S_DATA),
    .i_pop_rdy  (w_pop),
    .o_head_dat (w_head),
    .o_count    (w_count),
    .o_full     (w_full)
  );

  // First pixel (top byte of the stream word) goes to the lowest byte lane.
  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < NB; i++) begin
      w_wdata[8*i +: 8] = w_head[8*(NB-1-i) +: 8];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state      <= S_IDLE;
      r_active     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_wlast      <= 1'b0;
      r_bready     <= 1'b0;
      r_frame_done <= 1'b0;
      r_bresp_err  <= 1'b0;
      r_addr       <= '0;
      r_burst_cnt  <= '0;
      r_beat       <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_addr      <= {CAPADDR[C_M_AXI_ADDR_WIDTH-1:7], 7'b0};
            r_burst_cnt <= '0;
            r_active    <= 1'b1;
          end else if (r_active && !CAPON) begin
            r_active <= 1'b0;
          end else if (r_active && (w_count >= CNTW'(16))) begin
            r_awvalid <= 1'b1;
            r_state   <= S_AW;
          end
        end
        S_AW: begin
          if (M_AXI_AWREADY) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_wlast   <= 1'b0;
            r_beat    <= '0;
            r_state   <= S_W;
          end
        end
        S_W: begin
          if (M_AXI_WREADY) begin
            r_beat  <= r_beat + 4'd1;
            r_wlast <= (r_beat == 4'd14);
            if (r_beat == 4'd15) begin
              r_wvalid <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= S_B;
            end
          end
        end
        S_B: begin
          if (M_AXI_BVALID) begin
            r_bready    <= 1'b0;
            if (M_AXI_BRESP != 2'b00) r_bresp_err <= 1'b1;
            r_addr      <= r_addr + C_M_AXI_ADDR_WIDTH'(128);
            r_burst_cnt <= r_burst_cnt + CW'(1);
            if (r_burst_cnt == LAST_BURST) begin
              r_frame_done <= 1'b1;
              r_active     <= 1'b0;
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWLEN   = 8'd15;
  assign M_AXI_AWSIZE  = 3'd3;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWID    = '0;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_WDATA   = w_wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = r_wlast;
  assign M_AXI_BREADY  = r_bready;
  assign S_READY       = !r_active || !w_full;
  assign FRAME_DONE    = r_frame_done;
  assign BRESP_ERR     = r_bresp_err;
endmodule

// File: tb/tb_capture_wr.sv
// Randomized bench for capture_wr: a transaction-level model (word queue, pending AW/W/B counts) checks every cycle.
module tb_capture_wr;
  localparam int BPF   = 4;
  localparam int DEPTH = 32;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        M_AXI_AWREADY, M_AXI_AWVALID;
  logic [31:0] M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST;
  logic [3:0]  M_AXI_AWCACHE;
  logic [2:0]  M_AXI_AWPROT;
  logic [0:0]  M_AXI_AWID;
  logic        M_AXI_WREADY, M_AXI_WVALID, M_AXI_WLAST;
  logic [63:0] M_AXI_WDATA;
  logic [7:0]  M_AXI_WSTRB;
  logic        M_AXI_BVALID, M_AXI_BREADY;
  logic [1:0]  M_AXI_BRESP;
  logic [63:0] S_DATA;
  logic        S_VALID, S_READY;
  logic [31:0] CAPADDR;
  logic        CAPON, FRAME_DONE, BRESP_ERR;

  always #5 ACLK = ~ACLK;

  capture_wr #(.FIFO_DEPTH(DEPTH), .BURSTS_PER_FRAME(BPF)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWADDR(M_AXI_AWADDR),
    .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
    .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWID(M_AXI_AWID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WDATA(M_AXI_WDATA),
    .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BREADY(M_AXI_BREADY),
    .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
    .CAPADDR(CAPADDR), .CAPON(CAPON), .FRAME_DONE(FRAME_DONE), .BRESP_ERR(BRESP_ERR)
  );

  int checks = 0;
  int errors = 0;

  // Model: frame flag, buffered words, and what the AXI side still owes for the burst in flight.
  bit          m_active, m_aw_pending, m_b_pending, m_fd, m_err;
  int          m_w_left, m_burst;
  logic [31:0] m_addr;
  logic [63:0] m_q[$];

  int          n_push, n_aw, n_whs, n_b, n_fd;
  logic [31:0] aw_log[$];
  logic [63:0] first_wdata;
  bit          got_first, saw_not_ready;
  int          aw_delay, aw_wait, err_burst, push_limit;
  bit          w_rand, s_stream, pin_first;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rev(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_active = 0; m_aw_pending = 0; m_b_pending = 0; m_fd = 0; m_err = 0;
    m_w_left = 0; m_burst = 0; m_addr = '0;
    m_q.delete();
  endtask

  task automatic clear_stats();
    n_push = 0; n_aw = 0; n_whs = 0; n_b = 0; n_fd = 0;
    aw_log.delete(); got_first = 0; saw_not_ready = 0;
  endtask

  // One clock: sample pre-edge, advance the model, compare every output post-edge.
  task automatic step();
    bit          aw_hs, w_hs, b_hs, push, busy, capon;
    logic [63:0] wd, sd, exp_wd;
    logic        wl;
    logic [31:0] aa, ca;
    logic [1:0]  br;
    int          pre_size;
    #1;
    aw_hs = m_aw_pending && M_AXI_AWREADY;
    w_hs  = (m_w_left > 0) && M_AXI_WREADY;
    b_hs  = m_b_pending && M_AXI_BVALID;
    wd = M_AXI_WDATA; wl = M_AXI_WLAST; aa = M_AXI_AWADDR;
    sd = S_DATA; br = M_AXI_BRESP; capon = CAPON; ca = CAPADDR;
    pre_size = m_q.size();
    push = m_active && S_VALID && (pre_size < DEPTH);
    busy = m_aw_pending || (m_w_left > 0) || m_b_pending;
    @(posedge ACLK);
    #1;
    m_fd = 0;
    if (ARESETN) begin
      if (!busy) begin
        if (!m_active && capon) begin
          m_active = 1; m_addr = {ca[31:7], 7'b0}; m_burst = 0; m_q.delete();
        end else if (m_active && !capon) begin
          m_active = 0;
        end else if (m_active && pre_size >= 16) begin
          m_aw_pending = 1;
        end
      end
      if (aw_hs) begin
        chk("aw_addr", aa, m_addr);
        aw_log.push_back(aa); n_aw++;
        m_aw_pending = 0; m_w_left = 16;
      end
      if (w_hs) begin
        if (m_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_underflow actual=pop_of_empty_buffer expected=buffered_word");
        end else begin
          exp_wd = rev(m_q.pop_front());
          chk("wdata", wd, exp_wd);
        end
        chk("wlast_hs", wl, m_w_left == 1);
        if (!got_first) begin first_wdata = wd; got_first = 1; end
        m_w_left--; n_whs++;
        if (m_w_left == 0) m_b_pending = 1;
      end
      if (b_hs) begin
        m_b_pending = 0; n_b++;
        if (br != 2'b00) m_err = 1;
        m_addr = m_addr + 32'd128;
        m_burst++;
        if (m_burst == BPF) begin m_fd = 1; m_active = 0; n_fd++; end
      end
      if (push) begin m_q.push_back(sd); n_push++; end
    end
    if (!S_READY) saw_not_ready = 1;
    chk("s_ready", S_READY, !m_active || (m_q.size() < DEPTH));
    chk("awvalid", M_AXI_AWVALID, m_aw_pending);
    if (m_aw_pending) chk("awaddr_hold", M_AXI_AWADDR, m_addr);
    chk("wvalid", M_AXI_WVALID, m_w_left > 0);
    chk("wlast", M_AXI_WLAST, m_w_left == 1);
    chk("bready", M_AXI_BREADY, m_b_pending);
    chk("frame_done", FRAME_DONE, m_fd);
    chk("bresp_err", BRESP_ERR, m_err);
  endtask

  task automatic drive();
    if (M_AXI_AWVALID) begin
      if (aw_wait >= aw_delay) M_AXI_AWREADY = 1'b1;
      else begin M_AXI_AWREADY = 1'b0; aw_wait++; end
    end else begin
      M_AXI_AWREADY = (aw_delay == 0);
      aw_wait = 0;
    end
    M_AXI_WREADY = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    M_AXI_BVALID = M_AXI_BREADY && (w_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    M_AXI_BRESP  = (n_b == err_burst) ? 2'b10 : 2'b00;
    S_VALID      = s_stream && (n_push < push_limit);
    if (!(pin_first && n_push == 0)) S_DATA = {$urandom, $urandom};
  endtask

  task automatic run_n(input int n);
    repeat (n) begin step(); drive(); end
  endtask

  task automatic run_frames(input int target, input int budget, input string name);
    int cyc = 0;
    while (n_fd < target && cyc < budget) begin
      step();
      if (n_fd >= target) CAPON = 1'b0;
      drive();
      cyc++;
    end
    checks++;
    if (n_fd < target) begin
      errors++;
      $display("FAIL %s_timeout frames=%0d required=%0d", name, n_fd, target);
    end
  endtask

  initial begin
    ARESETN = 1'b0; CAPON = 1'b0; CAPADDR = '0; S_DATA = '0; S_VALID = 1'b0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    aw_delay = 0; aw_wait = 0; err_burst = -1; push_limit = 1 << 30;
    w_rand = 0; s_stream = 0; pin_first = 0;
    model_reset(); clear_stats();
    run_n(3);
    ARESETN = 1'b1;
    chk("awlen", M_AXI_AWLEN, 15);
    chk("awsize", M_AXI_AWSIZE, 3);
    chk("awburst", M_AXI_AWBURST, 1);
    chk("awcache", M_AXI_AWCACHE, 3);
    chk("awprot", M_AXI_AWPROT, 0);
    chk("awid", M_AXI_AWID, 0);
    chk("wstrb", M_AXI_WSTRB, 8'hFF);
    chk("rst_awaddr", M_AXI_AWADDR, 0);

    // Basic frame: 64 words, always-ready slave, first word pinned for byte order.
    clear_stats();
    CAPADDR = 32'h1000_0005; CAPON = 1'b1;
    run_n(3);
    S_DATA = 64'h0001_0203_0405_0607; pin_first = 1; push_limit = 64; s_stream = 1;
    run_frames(1, 2000, "basic");
    pin_first = 0; s_stream = 0; push_limit = 1 << 30;
    chk("basic_aw_count", aw_log.size(), 4);
    for (int i = 0; i < 4 && i < aw_log.size(); i++)
      chk("basic_awaddr", aw_log[i], 32'h1000_0000 + 32'(i) * 32'h80);
    chk("basic_beats", n_whs, 64);
    chk("basic_first_wdata", first_wdata, 64'h0706_0504_0302_0100);
    run_n(20);
    chk("basic_fd_count", n_fd, 1);

    // Backpressure: AWREADY held 10 cycles, random WREADY/BVALID.
    clear_stats();
    aw_delay = 10; w_rand = 1; s_stream = 1;
    CAPADDR = $urandom; CAPON = 1'b1;
    run_frames(1, 4000, "backpressure");
    chk("bp_beats", n_whs, 16 * BPF);
    s_stream = 0; run_n(10);

    // FIFO fill: long AW stall with continuous input.
    clear_stats();
    aw_delay = 60; w_rand = 0; s_stream = 1;
    CAPADDR = 32'h0800_0000; CAPON = 1'b1;
    run_frames(1, 4000, "fill");
    chk("fill_saw_full", saw_not_ready, 1);
    s_stream = 0; run_n(10);

    // Error response on the second burst; frame still completes.
    clear_stats();
    aw_delay = 0; w_rand = 1; err_burst = 1; s_stream = 1;
    CAPADDR = 32'h0C00_0080; CAPON = 1'b1;
    run_frames(1, 4000, "bresp");
    err_burst = -1;
    chk("bresp_sticky", BRESP_ERR, 1);
    chk("bresp_fd_count", n_fd, 1);
    run_n(10);

    // CAPON dropped during beat 5 of burst 1.
    clear_stats();
    aw_delay = 2; w_rand = 0; s_stream = 1;
    CAPADDR = 32'h2000_0100; CAPON = 1'b1;
    for (int c = 0; c < 500 && n_whs < 4; c++) begin step(); drive(); end
    chk("drop_reached_beat5", n_whs, 4);
    CAPON = 1'b0;
    run_n(60);
    chk("drop_aw_count", n_aw, 1);
    chk("drop_beats", n_whs, 16);
    chk("drop_fd_count", n_fd, 0);
    clear_stats();
    CAPADDR = 32'h3000_0044; CAPON = 1'b1;
    run_frames(1, 4000, "restart");
    if (aw_log.size() > 0) chk("restart_awaddr", aw_log[0], 32'h3000_0000);

    // Asynchronous reset in the middle of a W burst.
    clear_stats();
    aw_delay = 0; w_rand = 1; s_stream = 1;
    CAPADDR = 32'h5000_0000; CAPON = 1'b1;
    for (int c = 0; c < 500 && !(m_w_left > 0 && m_w_left <= 8); c++) begin step(); drive(); end
    chk("rst_reached_w", M_AXI_WVALID, 1);
    #2 ARESETN = 1'b0;
    #1;
    chk("rst_async_awvalid", M_AXI_AWVALID, 0);
    chk("rst_async_wvalid", M_AXI_WVALID, 0);
    chk("rst_async_bready", M_AXI_BREADY, 0);
    chk("rst_async_frame_done", FRAME_DONE, 0);
    chk("rst_async_bresp_err", BRESP_ERR, 0);
    model_reset();
    run_n(3);
    clear_stats();
    CAPADDR = 32'h4000_01FF;
    ARESETN = 1'b1;
    run_frames(1, 4000, "post_reset");
    if (aw_log.size() > 0) chk("post_reset_awaddr", aw_log[0], 32'h4000_0180);
    s_stream = 0; run_n(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/capture_wr.md
Name: capture_wr

Overview:
- AXI4 write master that captures a 64-bit pixel-word stream into a DDR frame buffer.
- It is the writer counterpart of the display read path.
- Incoming words are buffered in an internal FIFO and written as aligned 16-beat INCR bursts starting at a GPIO-supplied frame address.
- A frame-done pulse is raised after the last burst of a frame is acknowledged.

Parameters:
- C_M_AXI_THREAD_ID_WIDTH, 1, AWID/BID width.
- C_M_AXI_ADDR_WIDTH, 32, address width.
- C_M_AXI_DATA_WIDTH, 64, data width; only 64 is supported.
- FIFO_DEPTH, 32, input buffer depth in 64-bit words; power of 2, minimum 16.
- BURSTS_PER_FRAME, 2400, bursts per frame (640x480 8-bit pixels / 128 B).

Ports:
- ACLK  in  1  sole clock.
- ARESETN  in  1  asynchronous active-low reset.
- M_AXI_AWREADY  in  1  address accepted.
- M_AXI_AWVALID  out  1  address valid.
- M_AXI_AWADDR  out  32  burst address, 128-B aligned.
- M_AXI_AWLEN  out  8  constant 15.
- M_AXI_AWSIZE  out  3  constant 3.
- M_AXI_AWBURST  out  2  constant 2'b01.
- M_AXI_AWCACHE  out  4  constant 4'b0011.
- M_AXI_AWPROT  out  3  constant 0.
- M_AXI_AWID  out  ID  constant 0.
- M_AXI_WREADY  in  1  data accepted.
- M_AXI_WVALID  out  1  data valid.
- M_AXI_WDATA  out  64  write data.
- M_AXI_WSTRB  out  8  constant 8'hFF.
- M_AXI_WLAST  out  1  last beat.
- M_AXI_BVALID  in  1  response valid.
- M_AXI_BRESP  in  2  response code.
- M_AXI_BREADY  out  1  response ready.
- S_DATA  in  64  pixel word; [63:56] is the first pixel.
- S_VALID  in  1  word valid.
- S_READY  out  1  word accepted.
- CAPADDR  in  32  frame base address; bits [6:0] are ignored.
- CAPON  in  1  capture enable, level.
- FRAME_DONE  out  1  one-cycle pulse at end of frame.
- BRESP_ERR  out  1  sticky; set on any non-OKAY response.

Behaviour:
- Reset (ARESETN low, asynchronous): state IDLE, FIFO empty, frame inactive. AWVALID=0, WVALID=0, WLAST=0, BREADY=0, AWADDR=0, FRAME_DONE=0, BRESP_ERR=0.
- Byte order: WDATA = byte-reversed FIFO word. S_DATA[63:56] goes to WDATA[7:0], so pixel 0 lands at the lowest byte address.
- Frame start: in IDLE with the frame inactive and CAPON=1:
  - latch {CAPADDR[31:7],7'b0} into the address register;
  - clear the burst counter and flush the FIFO;
  - set the frame active (one cycle).
- Input accept:
  - S_READY = ~active | ~full.
  - While inactive, all words are accepted and discarded.
  - While active, a word is pushed when S_VALID & S_READY.
- FSM states: IDLE, AW, W, B.
  - IDLE -> AW when active & CAPON & fifo_count>=16. AWVALID asserts the next cycle.
  - AW: hold AWVALID and AWADDR stable until AWREADY. Then -> W.
  - W: WVALID=1, with data from the FIFO head. A beat counter (0..15) advances and the FIFO pops only on WVALID&WREADY. WLAST=1 when beat==15. The beat-15 handshake moves to B.
  - B: BREADY=1. On BVALID:
    - BRESP!=0 sets BRESP_ERR;
    - AWADDR += 128;
    - burst counter += 1;
    - if burst counter was BURSTS_PER_FRAME-1: pulse FRAME_DONE and clear active;
    - -> IDLE.
- No outstanding transactions: exactly one burst is in flight, and AW always precedes W.
- Bursts never cross 4 KB because every burst is 128-B aligned.
- Simultaneous push and pop in the W state keeps fifo_count unchanged. Full and empty are exact.
- The FIFO cannot underflow in W, because 16 words are guaranteed at AW issue and pops are the only removals.
- CAPON falling mid-frame:
  - an in-progress burst completes through B;
  - then active clears in IDLE, with no FRAME_DONE;
  - remaining FIFO data is flushed at the next frame start.
- CAPON still high after FRAME_DONE: a new frame starts from the current CAPADDR on the next IDLE cycle.
- BRESP_ERR clears only on reset.

Test Plan:
- BURSTS_PER_FRAME=4, CAPADDR=0x1000_0005, AXI always ready, 64 words streamed -> 4 bursts at AWADDR 0x10000000/080/100/180. Each burst has 16 beats with WLAST on beat 16, and a single FRAME_DONE pulse follows the 4th BVALID.
- S_DATA=0x0001020304050607 -> WDATA=0x0706050403020100.
- Hold AWREADY low 10 cycles and toggle WREADY 50% randomly -> AWADDR stable while waiting, no beat lost or duplicated, exactly 16 WVALID&WREADY per burst.
- AWREADY held low with S_VALID=1 continuously -> FIFO fills to 32 and S_READY=0. S_READY returns to 1 after the first W pop.
- BRESP=2'b10 on burst 2 -> BRESP_ERR=1 and remains set. The frame still completes and FRAME_DONE pulses.
- CAPON dropped during beat 5 of burst 1 -> the burst finishes with WLAST on beat 16 and BREADY handshake, then no new AWVALID and no FRAME_DONE. Re-raising CAPON restarts at CAPADDR.
- ARESETN asserted mid-W -> AWVALID, WVALID, BREADY and FRAME_DONE go low immediately (asynchronous), and the FIFO is empty after release.
